// File: rtl/ft60x_245fifo_dev_if.sv
// ---------------------------------------------------------------------------
// ft60x_245fifo_dev_if
// Bundles every signal of the FT60x 245 synchronous FIFO device model apart
// from clock and reset: the 245 bus pins, the host-side AXI-Stream ports and
// the sticky protocol error flags.
//
// Signals
//   usb_txe_n / usb_rxf_n            device -> master, buffer status (active low)
//   usb_wr_n / usb_rd_n / usb_oe_n   master -> device strobes (active low)
//   usb_data_i / usb_be_i            write data / byte enables from master
//   usb_data_o / usb_be_o            read data / byte enables to master
//   usb_data_t / usb_be_t            tristate controls, 1 = high-Z
//   s_axis_*                         host words into the RX buffer
//   m_axis_*                         FPGA-written words out of the TX buffer
//   err_oe_wr / err_wr_ovf / err_rd_unf  sticky protocol violation flags
//
// Modports
//   slave  : the device end (ft60x_245fifo_dev)
//   master : the environment (245 FIFO driver plus AXI-Stream host)
// ---------------------------------------------------------------------------
interface ft60x_245fifo_dev_if #(
    parameter int TDATA_WIDTH = 32
);
    localparam int BE_W = TDATA_WIDTH / 8;

    logic                   usb_txe_n;
    logic                   usb_rxf_n;
    logic                   usb_wr_n;
    logic                   usb_rd_n;
    logic                   usb_oe_n;
    logic [BE_W-1:0]        usb_be_i;
    logic [BE_W-1:0]        usb_be_o;
    logic [BE_W-1:0]        usb_be_t;
    logic [TDATA_WIDTH-1:0] usb_data_i;
    logic [TDATA_WIDTH-1:0] usb_data_o;
    logic [TDATA_WIDTH-1:0] usb_data_t;

    logic [TDATA_WIDTH-1:0] s_axis_tdata;
    logic [BE_W-1:0]        s_axis_tkeep;
    logic                   s_axis_tvalid;
    logic                   s_axis_tready;

    logic [TDATA_WIDTH-1:0] m_axis_tdata;
    logic [BE_W-1:0]        m_axis_tkeep;
    logic                   m_axis_tvalid;
    logic                   m_axis_tready;

    logic                   err_oe_wr;
    logic                   err_wr_ovf;
    logic                   err_rd_unf;

    modport slave (
        input  usb_wr_n, usb_rd_n, usb_oe_n, usb_be_i, usb_data_i,
        output usb_txe_n, usb_rxf_n, usb_be_o, usb_be_t, usb_data_o, usb_data_t,
        input  s_axis_tdata, s_axis_tkeep, s_axis_tvalid,
        output s_axis_tready,
        output m_axis_tdata, m_axis_tkeep, m_axis_tvalid,
        input  m_axis_tready,
        output err_oe_wr, err_wr_ovf, err_rd_unf
    );

    modport master (
        output usb_wr_n, usb_rd_n, usb_oe_n, usb_be_i, usb_data_i,
        input  usb_txe_n, usb_rxf_n, usb_be_o, usb_be_t, usb_data_o, usb_data_t,
        output s_axis_tdata, s_axis_tkeep, s_axis_tvalid,
        input  s_axis_tready,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tvalid,
        output m_axis_tready,
        input  err_oe_wr, err_wr_ovf, err_rd_unf
    );
endinterface

// File: rtl/ft60x_245fifo_dev.sv
// ---------------------------------------------------------------------------
// ft60x_245fifo_dev
// Device-side model of the FT60x 245 synchronous FIFO bus: the chip end that
// an FPGA-side 245 driver masters. An RX buffer is filled from a host
// AXI-Stream slave and read out over the bus; a TX buffer is filled by bus
// writes and drained to a host AXI-Stream master. Used as a loopback /
// emulation partner in simulation and FPGA-only bring-up builds.
//
// Parameters
//   TDATA_WIDTH  bus data width (16 or 32); byte enables are TDATA_WIDTH/8
//   FIFO_DEPTH   entries per buffer, power of two, >= 4
//
// Ports
//   usb_clk      bus clock, all logic on the rising edge
//   rst_usbclk   asynchronous active-high reset
//   bus          ft60x_245fifo_dev_if.slave (245 pins, AXI-Stream, error flags)
//
// Configuration macro
//   FT60X_PROTO_CHECK_EN  when defined, the sticky error flags are live and a
//                         simulation-only $error reports each violation;
//                         otherwise the flags are tied to 0.
// ---------------------------------------------------------------------------
module ft60x_245fifo_dev #(
    parameter int TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH  = 16
) (
    input logic                  usb_clk,
    input logic                  rst_usbclk,
    ft60x_245fifo_dev_if.slave   bus
);
    localparam int BE_W = TDATA_WIDTH / 8;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int EW   = TDATA_WIDTH + BE_W;

    typedef logic [AW:0] ptr_t;

    // Each entry stores {byte enables, data}.
    logic [EW-1:0] r_rxMem [FIFO_DEPTH];
    logic [EW-1:0] r_txMem [FIFO_DEPTH];
    ptr_t          r_rxWrPtr, r_rxRdPtr;
    ptr_t          r_txWrPtr, r_txRdPtr;

    logic          w_rxEmpty, w_rxFull, w_rxPush, w_rxPop;
    logic          w_txEmpty, w_txFull, w_txPush, w_txPop;
    logic [EW-1:0] w_rxHead, w_txHead;
    logic          w_drive;

    // Extra MSB on the pointers tells full (same slot, other lap) from empty.
    assign w_rxEmpty = (r_rxWrPtr == r_rxRdPtr);
    assign w_rxFull  = (r_rxWrPtr[AW] != r_rxRdPtr[AW]) &&
                       (r_rxWrPtr[AW-1:0] == r_rxRdPtr[AW-1:0]);
    assign w_txEmpty = (r_txWrPtr == r_txRdPtr);
    assign w_txFull  = (r_txWrPtr[AW] != r_txRdPtr[AW]) &&
                       (r_txWrPtr[AW-1:0] == r_txRdPtr[AW-1:0]);

    assign w_rxPush = bus.s_axis_tvalid && !w_rxFull;
    assign w_rxPop  = !bus.usb_rd_n && !w_rxEmpty;
    assign w_txPush = !bus.usb_wr_n && !w_txFull;
    assign w_txPop  = bus.m_axis_tready && !w_txEmpty;

    // Pointer updates; reset discards both buffers immediately.
    always_ff @(posedge usb_clk or posedge rst_usbclk) begin
        if (rst_usbclk) begin
            r_rxWrPtr <= '0;
            r_rxRdPtr <= '0;
            r_txWrPtr <= '0;
            r_txRdPtr <= '0;
        end else begin
            if (w_rxPush) r_rxWrPtr <= r_rxWrPtr + ptr_t'(1);
            if (w_rxPop)  r_rxRdPtr <= r_rxRdPtr + ptr_t'(1);
            if (w_txPush) r_txWrPtr <= r_txWrPtr + ptr_t'(1);
            if (w_txPop)  r_txRdPtr <= r_txRdPtr + ptr_t'(1);
        end
    end

    // Storage arrays need no reset; the pointers define what is valid.
    always_ff @(posedge usb_clk) begin
        if (w_rxPush) r_rxMem[r_rxWrPtr[AW-1:0]] <= {bus.s_axis_tkeep, bus.s_axis_tdata};
        if (w_txPush) r_txMem[r_txWrPtr[AW-1:0]] <= {bus.usb_be_i, bus.usb_data_i};
    end

    assign w_rxHead = r_rxMem[r_rxRdPtr[AW-1:0]];
    assign w_txHead = r_txMem[r_txRdPtr[AW-1:0]];

    // Read data is first-word fall-through; an empty RX buffer shows zeros so
    // the bus value is defined after reset and unchanged by dropped reads.
    assign bus.usb_data_o = w_rxEmpty ? '0 : w_rxHead[TDATA_WIDTH-1:0];
    assign bus.usb_be_o   = w_rxEmpty ? '0 : w_rxHead[EW-1:TDATA_WIDTH];

    // Reset releases the bus at once, even if the master still holds oe_n low.
    assign w_drive        = !bus.usb_oe_n && !rst_usbclk;
    assign bus.usb_data_t = {TDATA_WIDTH{!w_drive}};
    assign bus.usb_be_t   = {BE_W{!w_drive}};

    assign bus.usb_rxf_n     = w_rxEmpty;
    assign bus.usb_txe_n     = w_txFull;
    assign bus.s_axis_tready = !w_rxFull;
    assign bus.m_axis_tvalid = !w_txEmpty;
    assign bus.m_axis_tdata  = w_txHead[TDATA_WIDTH-1:0];
    assign bus.m_axis_tkeep  = w_txHead[EW-1:TDATA_WIDTH];

`ifdef FT60X_PROTO_CHECK_EN
    logic r_errOeWr, r_errWrOvf, r_errRdUnf;

    // Sticky protocol flags, cleared only by reset.
    always_ff @(posedge usb_clk or posedge rst_usbclk) begin
        if (rst_usbclk) begin
            r_errOeWr  <= 1'b0;
            r_errWrOvf <= 1'b0;
            r_errRdUnf <= 1'b0;
        end else begin
            if (!bus.usb_oe_n && !bus.usb_wr_n) r_errOeWr  <= 1'b1;
            if (!bus.usb_wr_n && w_txFull)      r_errWrOvf <= 1'b1;
            if (!bus.usb_rd_n && w_rxEmpty)     r_errRdUnf <= 1'b1;
        end
    end

    assign bus.err_oe_wr  = r_errOeWr;
    assign bus.err_wr_ovf = r_errWrOvf;
    assign bus.err_rd_unf = r_errRdUnf;

`ifndef SYNTHESIS
    // Simulation-only report of each individual violation.
    always @(posedge usb_clk) begin
        if (!rst_usbclk) begin
            if (!bus.usb_oe_n && !bus.usb_wr_n) $error("ft60x: oe_n and wr_n low together");
            if (!bus.usb_wr_n && w_txFull)      $error("ft60x: write while txe_n high");
            if (!bus.usb_rd_n && w_rxEmpty)     $error("ft60x: read while rxf_n high");
        end
    end
`endif
`else
    assign bus.err_oe_wr  = 1'b0;
    assign bus.err_wr_ovf = 1'b0;
    assign bus.err_rd_unf = 1'b0;
`endif

endmodule

// File: tb/tb_ft60x_245fifo_dev.sv
// ---------------------------------------------------------------------------
// tb_ft60x_245fifo_dev
// Self-checking bench for ft60x_245fifo_dev. A queue-based model of both
// buffers and the sticky error flags predicts every output; a negedge
// process compares the DUT against it every cycle, and directed sequences
// pin literal values (read order, tkeep, flag behaviour, reset mid-burst).
// ---------------------------------------------------------------------------
module tb_ft60x_245fifo_dev;
    localparam int TW    = 32;
    localparam int BW    = TW / 8;
    localparam int DEPTH = 16;
`ifdef FT60X_PROTO_CHECK_EN
    localparam logic CHECK_EN = 1'b1;
`else
    localparam logic CHECK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ft60x_245fifo_dev_if #(.TDATA_WIDTH(TW)) busIf();

    ft60x_245fifo_dev #(.TDATA_WIDTH(TW), .FIFO_DEPTH(DEPTH)) dut (
        .usb_clk    (clk),
        .rst_usbclk (rst),
        .bus        (busIf)
    );

    int checksTotal  = 0;
    int checksPassed = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checksTotal++;
        if (act === exp) checksPassed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Drive one cycle of inputs, then land 1 time unit after the next edge.
    task automatic applyStimulus(input logic wrN, input logic rdN, input logic oeN,
                                 input logic [TW-1:0] wData, input logic [BW-1:0] wBe,
                                 input logic sValid, input logic [TW-1:0] sData,
                                 input logic [BW-1:0] sKeep, input logic mReady);
        busIf.usb_wr_n      = wrN;
        busIf.usb_rd_n      = rdN;
        busIf.usb_oe_n      = oeN;
        busIf.usb_data_i    = wData;
        busIf.usb_be_i      = wBe;
        busIf.s_axis_tvalid = sValid;
        busIf.s_axis_tdata  = sData;
        busIf.s_axis_tkeep  = sKeep;
        busIf.m_axis_tready = mReady;
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: two bounded queues plus sticky flags.
    logic [TW+BW-1:0] rxQ[$];
    logic [TW+BW-1:0] txQ[$];
    logic mErrOeWr  = 1'b0;
    logic mErrWrOvf = 1'b0;
    logic mErrRdUnf = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rxQ.delete();
            txQ.delete();
            mErrOeWr  = 1'b0;
            mErrWrOvf = 1'b0;
            mErrRdUnf = 1'b0;
        end else begin
            logic rxPush, rxPop, txPush, txPop;
            if (!busIf.usb_oe_n && !busIf.usb_wr_n)          mErrOeWr  = 1'b1;
            if (!busIf.usb_wr_n && txQ.size() == DEPTH)      mErrWrOvf = 1'b1;
            if (!busIf.usb_rd_n && rxQ.size() == 0)          mErrRdUnf = 1'b1;
            rxPush = busIf.s_axis_tvalid && (rxQ.size() < DEPTH);
            rxPop  = !busIf.usb_rd_n && (rxQ.size() > 0);
            txPush = !busIf.usb_wr_n && (txQ.size() < DEPTH);
            txPop  = busIf.m_axis_tready && (txQ.size() > 0);
            if (rxPop)  void'(rxQ.pop_front());
            if (rxPush) rxQ.push_back({busIf.s_axis_tkeep, busIf.s_axis_tdata});
            if (txPop)  void'(txQ.pop_front());
            if (txPush) txQ.push_back({busIf.usb_be_i, busIf.usb_data_i});
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        logic [TW+BW-1:0] rxHead;
        logic             driven;
        rxHead = (rxQ.size() > 0) ? rxQ[0] : '0;
        driven = !rst && !busIf.usb_oe_n;
        checkOutput("rxf_n",   busIf.usb_rxf_n, rxQ.size() == 0);
        checkOutput("txe_n",   busIf.usb_txe_n, txQ.size() == DEPTH);
        checkOutput("s_tready", busIf.s_axis_tready, rxQ.size() < DEPTH);
        checkOutput("m_tvalid", busIf.m_axis_tvalid, txQ.size() > 0);
        if (txQ.size() > 0) begin
            checkOutput("m_tdata", busIf.m_axis_tdata, txQ[0][TW-1:0]);
            checkOutput("m_tkeep", busIf.m_axis_tkeep, txQ[0][TW+BW-1:TW]);
        end
        checkOutput("data_o", busIf.usb_data_o, rxHead[TW-1:0]);
        checkOutput("be_o",   busIf.usb_be_o,   rxHead[TW+BW-1:TW]);
        checkOutput("data_t", busIf.usb_data_t, driven ? {TW{1'b0}} : {TW{1'b1}});
        checkOutput("be_t",   busIf.usb_be_t,   driven ? {BW{1'b0}} : {BW{1'b1}});
        checkOutput("err_oe_wr",  busIf.err_oe_wr,  CHECK_EN && mErrOeWr);
        checkOutput("err_wr_ovf", busIf.err_wr_ovf, CHECK_EN && mErrWrOvf);
        checkOutput("err_rd_unf", busIf.err_rd_unf, CHECK_EN && mErrRdUnf);
    end

    localparam logic [TW-1:0] Z = '0;

    initial begin
        busIf.usb_wr_n = 1'b1; busIf.usb_rd_n = 1'b1; busIf.usb_oe_n = 1'b1;
        busIf.usb_data_i = '0; busIf.usb_be_i = '0;
        busIf.s_axis_tvalid = 1'b0; busIf.s_axis_tdata = '0; busIf.s_axis_tkeep = '0;
        busIf.m_axis_tready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset values.
        checkOutput("rst_rxf_n",  busIf.usb_rxf_n, 1);
        checkOutput("rst_txe_n",  busIf.usb_txe_n, 0);
        checkOutput("rst_data_t", busIf.usb_data_t, 32'hFFFF_FFFF);
        checkOutput("rst_be_t",   busIf.usb_be_t, 4'hF);
        checkOutput("rst_data_o", busIf.usb_data_o, 0);
        checkOutput("rst_tready", busIf.s_axis_tready, 1);
        checkOutput("rst_tvalid", busIf.m_axis_tvalid, 0);
        rst = 1'b0;

        // Load four words, assert oe_n, read four.
        for (int i = 0; i < 4; i++)
            applyStimulus(1, 1, 1, Z, 4'h0, 1, 32'h1111_1111 * (i + 1), 4'hF, 0);
        checkOutput("rxf_loaded", busIf.usb_rxf_n, 0);
        applyStimulus(1, 1, 0, Z, 4'h0, 0, Z, 4'h0, 0);
        checkOutput("data_t_driven", busIf.usb_data_t, 0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("rd_word", busIf.usb_data_o, 32'h1111_1111 * (i + 1));
            applyStimulus(1, 0, 0, Z, 4'h0, 0, Z, 4'h0, 0);
        end
        checkOutput("rxf_after_pops", busIf.usb_rxf_n, 1);
        checkOutput("no_err_rd", busIf.err_rd_unf, 0);
        checkOutput("no_err_oe", busIf.err_oe_wr, 0);
        applyStimulus(1, 1, 1, Z, 4'h0, 0, Z, 4'h0, 0);

        // Fill TX, overflow, then drain.
        for (int i = 0; i < 16; i++)
            applyStimulus(0, 1, 1, TW'(i), 4'hF, 0, Z, 4'h0, 0);
        checkOutput("txe_full", busIf.usb_txe_n, 1);
        applyStimulus(0, 1, 1, 32'hDEAD_BEEF, 4'hF, 0, Z, 4'h0, 0);
        checkOutput("err_wr_ovf_set", busIf.err_wr_ovf, CHECK_EN);
        for (int i = 0; i < 16; i++) begin
            checkOutput("tx_valid", busIf.m_axis_tvalid, 1);
            checkOutput("tx_data",  busIf.m_axis_tdata, i);
            checkOutput("tx_keep",  busIf.m_axis_tkeep, 4'hF);
            applyStimulus(1, 1, 1, Z, 4'h0, 0, Z, 4'h0, 1);
        end
        checkOutput("tx_drained", busIf.m_axis_tvalid, 0);

        // Partial byte enables.
        applyStimulus(0, 1, 1, 32'hCAFE_0003, 4'h3, 0, Z, 4'h0, 0);
        checkOutput("be3_valid", busIf.m_axis_tvalid, 1);
        checkOutput("be3_keep",  busIf.m_axis_tkeep, 4'h3);
        checkOutput("be3_data",  busIf.m_axis_tdata, 32'hCAFE_0003);
        applyStimulus(1, 1, 1, Z, 4'h0, 0, Z, 4'h0, 1);

        // Underflow read and oe/wr contention.
        checkOutput("unf_data_before", busIf.usb_data_o, 0);
        applyStimulus(1, 0, 1, Z, 4'h0, 0, Z, 4'h0, 0);
        checkOutput("unf_data_after", busIf.usb_data_o, 0);
        checkOutput("err_rd_unf_set", busIf.err_rd_unf, CHECK_EN);
        applyStimulus(0, 1, 0, 32'h5A5A_5A5A, 4'hF, 0, Z, 4'h0, 0);
        checkOutput("err_oe_wr_set", busIf.err_oe_wr, CHECK_EN);
        checkOutput("contention_captured", busIf.m_axis_tdata, 32'h5A5A_5A5A);
        applyStimulus(1, 1, 1, Z, 4'h0, 0, Z, 4'h0, 1);

        // 40 words streamed with simultaneous push and pop (pointers wrap twice).
        applyStimulus(1, 1, 1, Z, 4'h0, 1, 32'h1000_0000, 4'hF, 0);
        for (int i = 1; i < 40; i++) begin
            checkOutput("stream_word", busIf.usb_data_o, 32'h1000_0000 + i - 1);
            applyStimulus(1, 0, 0, Z, 4'h0, 1, 32'h1000_0000 + i, 4'hF, 0);
        end
        checkOutput("stream_last", busIf.usb_data_o, 32'h1000_0027);
        applyStimulus(1, 0, 0, Z, 4'h0, 0, Z, 4'h0, 0);
        checkOutput("stream_empty", busIf.usb_rxf_n, 1);

        // Reset in the middle of a 10-word read burst.
        applyStimulus(0, 1, 1, 32'h0000_00AA, 4'hF, 0, Z, 4'h0, 0);
        applyStimulus(0, 1, 1, 32'h0000_00BB, 4'hF, 0, Z, 4'h0, 0);
        for (int i = 0; i < 10; i++)
            applyStimulus(1, 1, 1, Z, 4'h0, 1, 32'h2000_0000 + i, 4'hF, 0);
        applyStimulus(1, 1, 0, Z, 4'h0, 0, Z, 4'h0, 0);
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 0, 0, Z, 4'h0, 0, Z, 4'h0, 0);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midrst_rxf_n",  busIf.usb_rxf_n, 1);
        checkOutput("midrst_data_t", busIf.usb_data_t, 32'hFFFF_FFFF);
        checkOutput("midrst_be_t",   busIf.usb_be_t, 4'hF);
        checkOutput("midrst_tvalid", busIf.m_axis_tvalid, 0);
        busIf.usb_rd_n = 1'b1;
        busIf.usb_oe_n = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1, 1, 1, Z, 4'h0, 0, Z, 4'h0, 0);
        checkOutput("post_rst_rxf_n",  busIf.usb_rxf_n, 1);
        checkOutput("post_rst_txe_n",  busIf.usb_txe_n, 0);
        checkOutput("post_rst_tvalid", busIf.m_axis_tvalid, 0);

        // Randomized traffic: first biased toward filling, then toward draining.
        for (int i = 0; i < 600; i++) begin
            logic fillPhase;
            fillPhase = (i < 300);
            applyStimulus(1'($urandom_range(0, fillPhase ? 1 : 3) == 0 ? 0 : 1) ^ 1'(fillPhase ? 0 : 0),
                          1'($urandom_range(0, fillPhase ? 3 : 1) != 0),
                          1'($urandom_range(0, 1)),
                          $urandom(), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, fillPhase ? 3 : 1) != 0),
                          $urandom(), 4'($urandom_range(0, 15)),
                          1'($urandom_range(0, fillPhase ? 3 : 1) == 0));
        end
        applyStimulus(1, 1, 1, Z, 4'h0, 0, Z, 4'h0, 0);

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end
endmodule
